// File: rtl/fsm_whiten_ctrl.sv
// Shared definitions for the whitening sequencer:
// state encodings and timer sizing.
package fsm_whiten_ctrl;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COV   = 3'd2,
    S_CONV  = 3'd3,
    S_EIG   = 3'd4,
    S_PROJ  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_whiten_ctrl;

  localparam int TIMEOUT = 65535;
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  // Timer must hold the watchdog and both settle latencies.
  function automatic int timer_w(
    input int t,
    input int a,
    input int b
  );
    int m;
    m = t;
    if (a > m) m = a;
    if (b > m) m = b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Loadable down-counter shared by every timed phase;
// holds at zero once expired.
module stage_timer
  import fsm_whiten_ctrl::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && !expired) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/whiten_ctrl.sv
// Whitening pipeline sequencer: latch, settle, eigen,
// projection, with watchdog on both handshakes.
module whiten_ctrl
  import fsm_whiten_ctrl::*;
#(
  parameter int COV_LAT  = 2,
  parameter int CONV_LAT = 3,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] scale,
  input  logic        eig_done,
  input  logic        proj_done,
  output logic        latch_en,
  output logic        eig_go,
  output logic        proj_go,
  output logic [31:0] scale_q,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  stage
);

  localparam int TW =
    timer_w(TIMEOUT, COV_LAT, CONV_LAT);

  // Timer counts down to zero, so load one less
  // than the number of cycles to spend in a phase.
  localparam logic [TW-1:0] COV_V  = TW'(COV_LAT - 1);
  localparam logic [TW-1:0] CONV_V = TW'(CONV_LAT - 1);
  localparam logic [TW-1:0] WD_V   = TW'(TIMEOUT - 1);

  state_whiten_ctrl state;
  logic             entry;
  logic             tmr_load;
  logic [TW-1:0]    tmr_value;
  logic             tmr_en;
  logic             expired;

  stage_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .en     (tmr_en),
    .expired(expired)
  );

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    unique case (state)
      S_LOAD: begin
        tmr_load  = 1'b1;
        tmr_value = COV_V;
      end
      S_COV: begin
        if (expired) begin
          tmr_load  = 1'b1;
          tmr_value = CONV_V;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_CONV: begin
        if (expired) begin
          tmr_load  = 1'b1;
          tmr_value = WD_V;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_EIG: begin
        if (!entry && eig_done) begin
          tmr_load  = 1'b1;
          tmr_value = WD_V;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_PROJ: tmr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      entry   <= 1'b0;
      scale_q <= '0;
    end else begin
      entry <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          scale_q <= scale;
          state   <= abort ? S_IDLE : S_COV;
        end
        S_COV: begin
          if (abort)        state <= S_IDLE;
          else if (expired) state <= S_CONV;
        end
        S_CONV: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (expired) begin
            state <= S_EIG;
            entry <= 1'b1;
          end
        end
        S_EIG: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (!entry && eig_done) begin
            state <= S_PROJ;
            entry <= 1'b1;
          end else if (!entry && expired) begin
            state <= S_ERROR;
          end
        end
        S_PROJ: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (!entry && proj_done) begin
            state <= S_DONE;
          end else if (!entry && expired) begin
            state <= S_ERROR;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERROR: begin
          if (start) state <= S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign latch_en = (state == S_LOAD);
  assign eig_go   = (state == S_EIG) && entry;
  assign proj_go  = (state == S_PROJ) && entry;
  assign busy     = (state == S_LOAD) ||
                    (state == S_COV)  ||
                    (state == S_CONV) ||
                    (state == S_EIG)  ||
                    (state == S_PROJ);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);
  assign stage    = state;

endmodule
